// File: rtl/mmio_console_uart_pkg.sv
// Shared register map, STATUS bit layout and serializer state encoding for the
// MMIO console UART.
package mmio_console_uart_pkg;

  localparam logic [15:0] OFF_TX_DATA = 16'h0000;
  localparam logic [15:0] OFF_STATUS  = 16'h0004;
  localparam logic [15:0] OFF_DIV     = 16'h0008;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_LEVEL_LSB = 8;

  typedef logic [1:0] ser_state_t;
  localparam ser_state_t S_IDLE  = 2'd0;
  localparam ser_state_t S_START = 2'd1;
  localparam ser_state_t S_DATA  = 2'd2;
  localparam ser_state_t S_STOP  = 2'd3;

  function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                              input logic busy, input logic ovf,
                                              input logic [7:0] level);
    logic [31:0] word;
    word                       = '0;
    word[ST_FULL]              = full;
    word[ST_EMPTY]             = empty;
    word[ST_BUSY]              = busy;
    word[ST_OVF]               = ovf;
    word[ST_LEVEL_LSB +: 8]    = level;
    return word;
  endfunction

endpackage

// File: rtl/mmio_console_uart_fifo.sv
// Show-ahead TX byte FIFO: rdata always presents the oldest entry, pop just
// advances the read pointer. Pointers carry an extra wrap bit for full/empty.
module mmio_console_uart_fifo #(
  parameter int PTR_WIDTH  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_WIDTH:0]    level
);

  localparam int DEPTH = 1 << PTR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]    wr_ptr;
  logic [PTR_WIDTH:0]    rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                   (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[PTR_WIDTH-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and this keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_WIDTH-1:0]] <= wdata;
  end

endmodule

// File: rtl/mmio_console_uart.sv
// Write-only console UART behind a three-register MMIO window: byte FIFO feeding
// an 8N1 serializer with a programmable bit period of DIV+1 clocks.
module mmio_console_uart
  import mmio_console_uart_pkg::*;
#(
  parameter logic [15:0] ADDR_BASE      = 16'h0100,
  parameter int          FIFO_PTR_WIDTH = 4,
  parameter logic [15:0] DIV_INIT       = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mmio_wr,
  input  logic        mmio_rd,
  input  logic [15:0] mmio_addr,
  input  logic [3:0]  mmio_sel,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  output logic        uart_tx,
  output logic        irq_tx_empty
);

  logic                    hit_tx, hit_status, hit_div;
  logic                    push_req, push_ok, ovf_set, clr_ovf;
  logic                    fifo_full, fifo_empty, pop;
  logic [7:0]              fifo_rdata;
  logic [FIFO_PTR_WIDTH:0] fifo_level;

  ser_state_t  state, state_nxt;
  logic [15:0] div;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        bit_end;
  logic        ovf;
  logic        unused;

  assign hit_tx     = (mmio_addr == ADDR_BASE + OFF_TX_DATA);
  assign hit_status = (mmio_addr == ADDR_BASE + OFF_STATUS);
  assign hit_div    = (mmio_addr == ADDR_BASE + OFF_DIV);

  assign push_req = mmio_wr && hit_tx && mmio_sel[0];
  assign push_ok  = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && fifo_full && !pop;
  assign clr_ovf  = mmio_wr && hit_status && mmio_sel[0] && mmio_wdata[ST_OVF];
  assign bit_end  = (baud_cnt == 16'd0);
  assign unused   = ^{mmio_wdata[31:16], mmio_sel[3:2]};

  mmio_console_uart_fifo #(
    .PTR_WIDTH  (FIFO_PTR_WIDTH),
    .DATA_WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .wdata (mmio_wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE:  if (!fifo_empty) begin state_nxt = S_START; pop = 1'b1; end
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA:  if (bit_end && bit_cnt == 3'd7) state_nxt = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin state_nxt = S_START; pop = 1'b1; end
          else state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      uart_tx      <= 1'b1;
      irq_tx_empty <= 1'b1;
      ovf          <= 1'b0;
      div          <= DIV_INIT;
      mmio_rdata   <= '0;
    end else begin
      state        <= state_nxt;
      irq_tx_empty <= (state_nxt == S_IDLE) && fifo_empty && !push_ok;

      // An overflowing push outranks a clear landing in the same cycle.
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;

      if (mmio_wr && hit_div && mmio_sel[0]) div[7:0]  <= mmio_wdata[7:0];
      if (mmio_wr && hit_div && mmio_sel[1]) div[15:8] <= mmio_wdata[15:8];

      if (mmio_rd) begin
        if (hit_status)
          mmio_rdata <= pack_status(fifo_full, fifo_empty, state != S_IDLE, ovf,
                                    8'(fifo_level));
        else if (hit_div)
          mmio_rdata <= {16'h0000, div};
        else
          mmio_rdata <= '0;
      end

      // DIV is only sampled when a bit starts, so a write never stretches a bit.
      if (pop) begin
        shift    <= fifo_rdata;
        baud_cnt <= div;
        uart_tx  <= 1'b0;
      end else if (state != S_IDLE) begin
        if (bit_end) begin
          baud_cnt <= div;
          bit_cnt  <= (state == S_START) ? 3'd0 : bit_cnt + 3'd1;
          if (state == S_START || (state == S_DATA && bit_cnt != 3'd7)) begin
            uart_tx <= shift[0];
            shift   <= {1'b0, shift[7:1]};
          end else begin
            uart_tx <= 1'b1;
          end
        end else begin
          baud_cnt <= baud_cnt - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_console_uart.sv
// Randomised self-checking bench for mmio_console_uart: serial line captured per
// clock and compared against frames built from the 8N1 rules.
module tb_mmio_console_uart;

  localparam logic [15:0] A_TX  = 16'h0100;
  localparam logic [15:0] A_ST  = 16'h0104;
  localparam logic [15:0] A_DIV = 16'h0108;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mmio_wr = 1'b0;
  logic        mmio_rd = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [3:0]  mmio_sel = '0;
  logic [31:0] mmio_wdata = '0;
  logic [31:0] mmio_rdata;
  logic        uart_tx;
  logic        irq_tx_empty;

  int checks = 0;
  int failures = 0;

  bit capture = 1'b0;
  bit line_q[$];
  bit exp_q[$];

  mmio_console_uart dut (
    .clk          (clk),
    .reset        (reset),
    .mmio_wr      (mmio_wr),
    .mmio_rd      (mmio_rd),
    .mmio_addr    (mmio_addr),
    .mmio_sel     (mmio_sel),
    .mmio_wdata   (mmio_wdata),
    .mmio_rdata   (mmio_rdata),
    .uart_tx      (uart_tx),
    .irq_tx_empty (irq_tx_empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (capture) line_q.push_back(uart_tx);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus helpers ----------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic mmio_write(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d);
    @(negedge clk);
    mmio_wr = 1'b1; mmio_addr = a; mmio_sel = s; mmio_wdata = d;
    @(negedge clk);
    mmio_wr = 1'b0; mmio_sel = '0;
  endtask

  task automatic mmio_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    mmio_rd = 1'b1; mmio_addr = a;
    @(negedge clk);
    mmio_rd = 1'b0;
    d = mmio_rdata;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (irq_tx_empty) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] status_word(input bit full, input bit empty, input bit busy,
                                              input bit ovf, input int level);
    return level * 256 + (ovf ? 8 : 0) + (busy ? 4 : 0) + (empty ? 2 : 0) + (full ? 1 : 0);
  endfunction

  // One 8N1 frame: start low, eight data bits LSB first, stop high.
  function automatic void add_frame(input logic [7:0] b, input int start_len, input int bit_len);
    repeat (start_len) exp_q.push_back(1'b0);
    for (int k = 0; k < 8; k++) repeat (bit_len) exp_q.push_back(b[k]);
    repeat (bit_len) exp_q.push_back(1'b1);
  endfunction

  // Mismatching samples from the first low sample onward; idle must follow.
  function automatic int line_errors();
    int s;
    int errs;
    s = -1;
    errs = 0;
    for (int i = 0; i < line_q.size(); i++)
      if (line_q[i] == 1'b0) begin s = i; break; end
    if (s < 0) return -1;
    if (line_q.size() < s + exp_q.size()) return -2;
    for (int i = 0; i < exp_q.size(); i++)
      if (line_q[s + i] !== exp_q[i]) errs++;
    for (int i = s + exp_q.size(); i < line_q.size(); i++)
      if (line_q[i] !== 1'b1) errs++;
    return errs;
  endfunction

  function automatic int count_low();
    int n;
    n = 0;
    foreach (line_q[i]) if (line_q[i] !== 1'b1) n++;
    return n;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    do_reset(3);
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    checks++; if (irq_tx_empty !== 1'b1) begin failures++; $display("FAIL reset_irq: got %b want 1", irq_tx_empty); end
    checks++; if (mmio_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", mmio_rdata); end
    mmio_read(A_ST, d);
    checks++; if (d !== status_word(0, 1, 0, 0, 0)) begin failures++; $display("FAIL reset_status: got %h want %h", d, status_word(0, 1, 0, 0, 0)); end
  endtask

  task automatic test_registers();
    logic [31:0] d;
    mmio_read(A_DIV, d);
    checks++; if (d !== 32'd867) begin failures++; $display("FAIL div_init: got %h want %h", d, 32'd867); end
    mmio_write(A_DIV, 4'b0001, 32'h0000_0007);
    mmio_read(A_DIV, d);
    checks++; if (d !== 32'h0000_0307) begin failures++; $display("FAIL div_lane0: got %h want 00000307", d); end
    mmio_write(A_DIV, 4'b0010, 32'h0000_AB00);
    mmio_read(A_DIV, d);
    checks++; if (d !== 32'h0000_AB07) begin failures++; $display("FAIL div_lane1: got %h want 0000ab07", d); end
    mmio_write(A_DIV, 4'b1111, 32'hFFFF_0012);
    mmio_read(A_DIV, d);
    checks++; if (d !== 32'h0000_0012) begin failures++; $display("FAIL div_upper: got %h want 00000012", d); end
    // Read data must hold while the strobe is low, even as the address moves.
    @(negedge clk); mmio_addr = A_ST;
    repeat (3) @(negedge clk);
    checks++; if (mmio_rdata !== 32'h0000_0012) begin failures++; $display("FAIL rdata_hold: got %h want 00000012", mmio_rdata); end
    mmio_read(A_TX, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL txdata_read: got %h want 0", d); end
    mmio_read(16'h010C, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read: got %h want 0", d); end
  endtask

  task automatic test_single_frame();
    int errs;
    bit irq_last;
    do_reset(2);
    mmio_write(A_DIV, 4'b0011, 32'd3);
    exp_q.delete();
    add_frame(8'h41, 4, 4);
    mmio_write(A_TX, 4'b0001, 32'h0000_0041);
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL frame_pre_idle: got %b want 1", uart_tx); end
    errs = 0;
    irq_last = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (uart_tx !== exp_q[i]) errs++;
      irq_last = irq_tx_empty;
    end
    checks++; if (errs !== 0) begin failures++; $display("FAIL frame_0x41: got %0d bad samples want 0", errs); end
    checks++; if (irq_last !== 1'b0) begin failures++; $display("FAIL irq_during_stop: got %b want 0", irq_last); end
    @(negedge clk);
    checks++; if (irq_tx_empty !== 1'b1 || uart_tx !== 1'b1) begin failures++; $display("FAIL irq_after_stop: got irq=%b tx=%b want 1/1", irq_tx_empty, uart_tx); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int max_level;
    int n;
    bit done;
    mmio_write(A_DIV, 4'b0011, 32'd1);
    exp_q.delete();
    add_frame(8'h48, 2, 2); add_frame(8'h69, 2, 2); add_frame(8'h0A, 2, 2);
    line_q.delete();
    capture = 1'b1;
    mmio_write(A_TX, 4'b0001, 32'h48);
    mmio_write(A_TX, 4'b0001, 32'h69);
    mmio_write(A_TX, 4'b0001, 32'h0A);
    max_level = 0;
    done = 1'b0;
    for (n = 0; n < 100; n++) begin
      mmio_read(A_ST, d);
      if (int'(d[15:8]) > max_level) max_level = int'(d[15:8]);
      if (irq_tx_empty) begin done = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    capture = 1'b0;
    checks++; if (!done) begin failures++; $display("FAIL b2b_idle: irq never rose within 100 reads"); end
    checks++; if (max_level !== 2) begin failures++; $display("FAIL b2b_peak_level: got %0d want 2", max_level); end
    n = line_errors();
    checks++; if (n !== 0) begin failures++; $display("FAIL b2b_line: got %0d bad samples want 0", n); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    do_reset(2);
    mmio_write(A_DIV, 4'b0011, 32'd100);
    // The first byte moves straight into the serializer, so 17 pushes leave
    // 16 queued (full) and the 18th is the first one dropped.
    for (int i = 0; i < 17; i++) mmio_write(A_TX, 4'b0001, $urandom);
    mmio_read(A_ST, d);
    checks++; if (d !== status_word(1, 0, 1, 0, 16)) begin failures++; $display("FAIL ovf_full: got %h want %h", d, status_word(1, 0, 1, 0, 16)); end
    mmio_write(A_TX, 4'b0001, $urandom);
    mmio_read(A_ST, d);
    checks++; if (d !== status_word(1, 0, 1, 1, 16)) begin failures++; $display("FAIL ovf_set: got %h want %h", d, status_word(1, 0, 1, 1, 16)); end
    mmio_write(A_ST, 4'b0010, 32'h8);
    mmio_read(A_ST, d);
    checks++; if (d !== status_word(1, 0, 1, 1, 16)) begin failures++; $display("FAIL ovf_wrong_lane: got %h want %h", d, status_word(1, 0, 1, 1, 16)); end
    mmio_write(A_ST, 4'b0001, 32'h8);
    mmio_read(A_ST, d);
    checks++; if (d !== status_word(1, 0, 1, 0, 16)) begin failures++; $display("FAIL ovf_clear: got %h want %h", d, status_word(1, 0, 1, 0, 16)); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    logic [7:0] b0;
    do_reset(2);
    mmio_write(A_DIV, 4'b0011, 32'd3);
    b0 = 8'($urandom) & 8'hEF;            // data bit 4 low, so the abort is visible
    mmio_write(A_TX, 4'b0001, {24'h0, b0});
    // Frame sample 0 is the next negedge; each bus access advances two samples.
    for (int i = 0; i < 3; i++) mmio_write(A_TX, 4'b0001, $urandom);
    mmio_read(A_ST, d);
    checks++; if (d !== status_word(0, 0, 1, 0, 3)) begin failures++; $display("FAIL abort_queued: got %h want %h", d, status_word(0, 0, 1, 0, 3)); end
    repeat (14) @(negedge clk);           // sample 21: inside data bit 4
    checks++; if (uart_tx !== 1'b0) begin failures++; $display("FAIL abort_bit4: got %b want 0", uart_tx); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL abort_tx: got %b want 1", uart_tx); end
    reset = 1'b1;
    mmio_read(A_ST, d);
    checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL abort_status: got %h want 00000002", d); end
    line_q.delete();
    capture = 1'b1;
    repeat (60) @(negedge clk);
    capture = 1'b0;
    checks++; if (count_low() !== 0 || irq_tx_empty !== 1'b1) begin failures++; $display("FAIL abort_quiet: got %0d low samples irq=%b want 0/1", count_low(), irq_tx_empty); end
  endtask

  task automatic test_window();
    logic [31:0] d;
    mmio_write(A_DIV, 4'b0011, 32'd1);
    line_q.delete();
    capture = 1'b1;
    mmio_write(16'h0200, 4'b0001, 32'h55);
    mmio_write(A_TX, 4'b0010, 32'h55);
    repeat (30) @(negedge clk);
    capture = 1'b0;
    checks++; if (count_low() !== 0) begin failures++; $display("FAIL window_no_frame: got %0d low samples want 0", count_low()); end
    mmio_read(A_ST, d);
    checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL window_status: got %h want 00000002", d); end
    mmio_read(16'h0204, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL window_alias_read: got %h want 0", d); end
  endtask

  task automatic test_random_frames();
    logic [31:0] d;
    logic [7:0] b;
    int div, n, errs;
    bit ok;
    for (int r = 0; r < 3; r++) begin
      div = $urandom_range(0, 4);
      n = $urandom_range(2, 4);
      mmio_write(A_DIV, 4'b0011, div);
      exp_q.delete();
      line_q.delete();
      capture = 1'b1;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        add_frame(b, div + 1, div + 1);
        mmio_write(A_TX, 4'b0001, {24'h0, b});
      end
      wait_idle(400, ok);
      repeat (3) @(negedge clk);
      capture = 1'b0;
      errs = line_errors();
      checks++; if (!ok || errs !== 0) begin failures++; $display("FAIL rand_line[%0d]: div=%0d n=%0d idle=%b bad=%0d want idle=1 bad=0", r, div, n, ok, errs); end
      mmio_read(A_ST, d);
      checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL rand_status[%0d]: got %h want 00000002", r, d); end
    end
  endtask

  task automatic test_div_boundary();
    logic [7:0] b;
    int errs;
    bit ok;
    mmio_write(A_DIV, 4'b0011, 32'd7);
    b = 8'($urandom);
    exp_q.delete();
    add_frame(b, 8, 2);                   // start bit keeps the old period
    line_q.delete();
    capture = 1'b1;
    mmio_write(A_TX, 4'b0001, {24'h0, b});
    mmio_write(A_DIV, 4'b0011, 32'd1);    // lands during the start bit
    wait_idle(200, ok);
    repeat (3) @(negedge clk);
    capture = 1'b0;
    errs = line_errors();
    checks++; if (!ok || errs !== 0) begin failures++; $display("FAIL div_boundary: idle=%b bad=%0d want idle=1 bad=0", ok, errs); end
  endtask

  initial begin
    test_reset();
    test_registers();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_window();
    test_random_frames();
    test_div_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
